// File: rtl/ro_meas_if.sv
// rtl/ro_meas_if.sv - Control/result bundle between a measurement requester and ro_meas_ctrl.
interface ro_meas_if #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic              ro_in;
  logic              ro_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output start, abort, gate_len, ro_in,
    input  ro_en, busy, done, count, overflow
  );

  modport slave (
    input  start, abort, gate_len, ro_in,
    output ro_en, busy, done, count, overflow
  );
endinterface

// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - Ring oscillator sequencer: enable, settle, count edges over a gate window.
module ro_meas_ctrl #(
  parameter int GATE_W     = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16
) (
  input logic      clk,
  input logic      rst,
  ro_meas_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int               SET_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [1:0]        state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              ro_edge;

  assign ro_edge = s2_q & ~s3_q;

  // Settle and gate counters hold "cycles remaining minus one", so zero marks the last cycle.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    gate_d     = gate_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          gate_d   = (bus.gate_len == '0) ? '0 : bus.gate_len - GATE_W'(1);
          settle_d = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (settle_q == '0) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_MEASURE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (ro_edge) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
          end
          // Publish including an edge seen on the final gate cycle.
          if (gate_q == '0) begin
            state_d    = S_DONE;
            count_d    = cnt_d;
            overflow_d = ovf_d;
          end else begin
            gate_d = gate_q - GATE_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      settle_q   <= '0;
      gate_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= bus.ro_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.ro_en    = (state_q == S_SETTLE) || (state_q == S_MEASURE);
  assign bus.busy     = (state_q == S_SETTLE) || (state_q == S_MEASURE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
Sequencer for the on-die ring oscillator. It enables the ring, waits a settle interval, then counts ring rising edges over a programmable gate window of system clocks. It reports the edge count with a done pulse, so firmware or the pin-level harness can read the ring frequency as count / gate_len × f_clk. The ring output enters as an asynchronous signal and is synchronized internally; all logic runs on the single system clock.

Parameters:
GATE_W, 16, width of gate_len (measurement window length in clk cycles)
CNT_W, 16, width of edge counter / result
SETTLE_CYC, 16, clk cycles ro_en is held high before counting starts (≥1)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a measurement; sampled only in IDLE
abort  input  1  cancel measurement in progress
gate_len  input  GATE_W  window length in clk cycles; sampled at accepted start
ro_in  input  1  raw ring oscillator output (asynchronous to clk)
ro_en  output  1  ring enable
busy  output  1  high in SETTLE and MEASURE
done  output  1  one-cycle pulse, result valid
count  output  CNT_W  rising edges seen in last completed window
overflow  output  1  last window saturated the counter

Behaviour:
- Reset (async, rst=1): state IDLE; ro_en=0, busy=0, done=0, count=0, overflow=0; sync flops, settle/gate/edge counters = 0.
- Synchronizer: ro_in → s1 → s2 (2 flops), s3 = delayed s2; edge = s2 & ~s3. Runs in all states.
- States: IDLE, SETTLE, MEASURE, DONE.
- IDLE: ro_en=0. start=1 & abort=0 → latch gate_len (0 is treated as 1), load settle counter, go SETTLE. start with abort the same cycle → stay IDLE.
- SETTLE: ro_en=1, busy=1. Stay exactly SETTLE_CYC cycles, then MEASURE. Edge counter cleared on the transition.
- MEASURE: ro_en=1, busy=1. Stay exactly latched gate_len cycles. Every cycle in MEASURE with edge=1 increments the edge counter, including the first and last cycles. Counter saturates at 2^CNT_W−1; an edge while saturated sets the internal ovf flag (cleared on entry to MEASURE). Then go DONE.
- DONE (1 cycle): done=1, busy=0, ro_en=0. count and overflow are updated in this same cycle from the edge counter and ovf flag, then held until the next DONE or reset. Next state IDLE.
- Latency: start accepted at edge k → ro_en high from cycle k+1 → done high in cycle k+1+SETTLE_CYC+gate_len.
- start while busy or in DONE: ignored, no queuing.
- abort in SETTLE or MEASURE: next cycle IDLE, ro_en=0, no done pulse, count/overflow keep their previous values. abort in IDLE/DONE: no effect (DONE still completes).
- gate_len changes after start: no effect until the next start.
- Max detectable edge rate: one per 2 clk; faster rings alias (documented limitation, not an error).
- rst asserted mid-operation: immediate return to reset values; ro_en drops asynchronously.

Test Plan:
1. Reset values: hold rst with ro_in toggling → ro_en=0, busy=0, done=0, count=0, overflow=0; release, no start → all stay 0.
2. Nominal: defaults, ro_in toggles every 4 clk (period 8), start with gate_len=80 → ro_en rises next cycle, done pulses exactly 1+16+80 cycles after start, count=10, overflow=0, busy low from done onward.
3. Overflow: CNT_W=4, ro_in toggles every clk, gate_len=64 → count=15, overflow=1; rerun with gate_len=20 → count=10, overflow=0.
4. Abort: start, assert abort 5 cycles into MEASURE → next cycle IDLE, ro_en=0, no done, count retains the prior value (10 from scenario 2).
5. Ignored start / edge cases: pulse start during MEASURE → single done only. start+abort together in IDLE → stays IDLE. gate_len=0 → done at 1+16+1 cycles after start.
6. Async reset mid-MEASURE: assert rst off-edge → ro_en, busy, count drop to 0 before the next clk edge; a fresh start then completes normally.
